// File: rtl/router_pkg.sv
// router_pkg: shared widths, address constants and byte type for the 1x3 router.
`default_nettype none

package router_pkg;
   localparam int                DATA_W       = 8;
   localparam int                ADDR_W       = 2;
   localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

   typedef logic [DATA_W-1:0] byte_t;
endpackage

`default_nettype wire

// File: rtl/register_parity.sv
// register_parity: running packet XOR parity, packet parity byte capture and err compare.
// Instantiated by register only when REGISTER_PARITY_CHECK_EN is defined.
`default_nettype none

module register_parity
   import router_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              pkt_valid,
   input  logic              fifo_full,
   input  logic              low_pkt_valid,
   input  logic              parity_done,
   input  logic [DATA_W-1:0] hdr,
   input  logic [DATA_W-1:0] full_byte,
   input  logic [DATA_W-1:0] data_in,
   output logic              err
);

   byte_t int_parity;
   byte_t pkt_parity;

   // A byte taken while the FIFO is full is folded in on its first sample only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         int_parity <= '0;
      else if (detect_add)
         int_parity <= '0;
      else if (lfd_state)
         int_parity <= int_parity ^ hdr;
      else if (ld_state && pkt_valid && !full_state)
         int_parity <= int_parity ^ data_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pkt_parity <= '0;
      else if (detect_add)
         pkt_parity <= '0;
      else if (ld_state && !pkt_valid && !fifo_full)
         pkt_parity <= data_in;
      else if (laf_state && low_pkt_valid && !parity_done)
         pkt_parity <= full_byte;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err <= 1'b0;
      else if (detect_add)
         err <= 1'b0;
      else if (parity_done)
         err <= (int_parity != pkt_parity);
   end

endmodule

`default_nettype wire

// File: rtl/register.sv
// register: router input data register (header latch, FIFO write byte, full-hold byte, flags).
// Parity checking is built only with REGISTER_PARITY_CHECK_EN; otherwise err is tied 0.
`default_nettype none

module register
   import router_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              pkt_valid,
   input  logic              fifo_full,
   input  logic              rst_int_reg,
   input  logic              detect_add,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] data_in,
   output logic              parity_done,
   output logic              low_pkt_valid,
   output logic              err,
   output logic [DATA_W-1:0] dout
);

   byte_t hdr;
   byte_t full_byte;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         hdr <= '0;
      else if (detect_add && pkt_valid && (data_in[ADDR_W-1:0] != INVALID_ADDR))
         hdr <= data_in;
   end

   // While the FIFO is full the byte is parked in full_byte and replayed in LOAD_AFTER_FULL.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout      <= '0;
         full_byte <= '0;
      end else if (lfd_state) begin
         dout <= hdr;
      end else if (ld_state && !fifo_full) begin
         dout <= data_in;
      end else if (ld_state && fifo_full) begin
         full_byte <= data_in;
      end else if (laf_state) begin
         dout <= full_byte;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         low_pkt_valid <= 1'b0;
      else if (rst_int_reg)
         low_pkt_valid <= 1'b0;
      else if (ld_state && !pkt_valid)
         low_pkt_valid <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         parity_done <= 1'b0;
      else if (detect_add)
         parity_done <= 1'b0;
      else if ((ld_state && !fifo_full && !pkt_valid) ||
               (laf_state && low_pkt_valid && !parity_done))
         parity_done <= 1'b1;
   end

`ifdef REGISTER_PARITY_CHECK_EN
   register_parity u_parity (
      .clk           (clk),
      .rst           (rst),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .pkt_valid     (pkt_valid),
      .fifo_full     (fifo_full),
      .low_pkt_valid (low_pkt_valid),
      .parity_done   (parity_done),
      .hdr           (hdr),
      .full_byte     (full_byte),
      .data_in       (data_in),
      .err           (err)
   );
`else
   logic unused_full_state;
   assign unused_full_state = full_state;
   assign err               = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_register.sv
// tb_register: randomized packet-level bench for register against a transaction reference model.
`default_nettype none

module tb_register;
   import router_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   logic  pkt_valid, fifo_full, rst_int_reg, detect_add;
   logic  ld_state, laf_state, full_state, lfd_state;
   byte_t data_in;
   logic  parity_done, low_pkt_valid, err;
   byte_t dout;

   int checks = 0;
   int errors = 0;

   // reference model: last accepted header and last byte put on the FIFO bus
   byte_t m_hdr  = 8'h00;
   byte_t m_dout = 8'h00;

   register dut (
      .clk           (clk),
      .rst           (rst),
      .pkt_valid     (pkt_valid),
      .fifo_full     (fifo_full),
      .rst_int_reg   (rst_int_reg),
      .detect_add    (detect_add),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .lfd_state     (lfd_state),
      .data_in       (data_in),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .err           (err),
      .dout          (dout)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      pkt_valid   = 1'b0;
      fifo_full   = 1'b0;
      rst_int_reg = 1'b0;
      detect_add  = 1'b0;
      ld_state    = 1'b0;
      laf_state   = 1'b0;
      full_state  = 1'b0;
      lfd_state   = 1'b0;
      data_in     = byte_t'($urandom);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dout"}, dout, 0);
      check({tag, "_pdone"}, parity_done, 0);
      check({tag, "_lpv"}, low_pkt_valid, 0);
      check({tag, "_err"}, err, 0);
   endtask

   // Drives one packet as the router FSM would and checks the register against packet-level expectations.
   task automatic send_packet(input byte_t header, input int len, input bit corrupt,
                              input int stall_pct, input bit par_stall);
      byte_t b;
      byte_t sum;
      byte_t par;
      logic  exp_err;

      clear_inputs(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = header; tick();
      if (header[1:0] != INVALID_ADDR) m_hdr = header;
      check("dec_pdone", parity_done, 0);
      check("dec_err", err, 0);

      clear_inputs(); lfd_state = 1'b1; pkt_valid = 1'b1; tick();
      m_dout = m_hdr;
      check("hdr_out", dout, m_dout);

      sum = m_hdr;
      for (int i = 0; i < len; i++) begin
         b   = byte_t'($urandom);
         sum = sum ^ b;
         if (int'($urandom_range(99)) < stall_pct) begin
            clear_inputs(); ld_state = 1'b1; fifo_full = 1'b1; pkt_valid = 1'b1; data_in = b; tick();
            check("stall_hold", dout, m_dout);
            clear_inputs(); full_state = 1'b1; fifo_full = 1'b1; pkt_valid = 1'b1; tick();
            check("full_hold", dout, m_dout);
            clear_inputs(); laf_state = 1'b1; pkt_valid = 1'b1; tick();
            m_dout = b;
            check("laf_out", dout, m_dout);
         end else begin
            clear_inputs(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = b; tick();
            m_dout = b;
            check("pay_out", dout, m_dout);
         end
      end
      check("pay_lpv", low_pkt_valid, 0);
      check("pay_pdone", parity_done, 0);

      par = corrupt ? (sum ^ 8'h01) : sum;
      if (par_stall) begin
         clear_inputs(); ld_state = 1'b1; fifo_full = 1'b1; data_in = par; tick();
         check("parfull_hold", dout, m_dout);
         check("parfull_lpv", low_pkt_valid, 1);
         check("parfull_pdone", parity_done, 0);
         clear_inputs(); laf_state = 1'b1; tick();
      end else begin
         clear_inputs(); ld_state = 1'b1; data_in = par; tick();
      end
      m_dout = par;
      check("par_out", dout, m_dout);
      check("par_pdone", parity_done, 1);
      check("par_lpv", low_pkt_valid, 1);

`ifdef REGISTER_PARITY_CHECK_EN
      exp_err = (par != sum);
`else
      exp_err = 1'b0;
`endif
      clear_inputs(); tick();
      check("err_val", err, exp_err);
      check("idle_dout", dout, m_dout);

      clear_inputs(); rst_int_reg = 1'b1; tick();
      check("rint_lpv", low_pkt_valid, 0);
      check("rint_pdone", parity_done, 1);
      check("rint_err", err, exp_err);

      clear_inputs(); tick();
      check("hold_err", err, exp_err);
   endtask

   initial begin
      byte_t h;
      clear_inputs();
      rst = 1'b0;
      tick(); tick();
      check_all_zero("rst");
      #2 rst = 1'b1;
      tick(); tick();
      check_all_zero("post_rst");

      // directed: good packet, corrupted parity, invalid address, full-hold paths
      send_packet(8'h2A, 10, 1'b0, 0, 1'b0);
      send_packet(8'h2A, 10, 1'b1, 0, 1'b0);
      send_packet(8'h2B, 4, 1'b0, 0, 1'b0);
      check("inval_hdr", m_hdr, 8'h2A);
      send_packet(8'h55, 6, 1'b0, 100, 1'b1);
      send_packet(8'h14, 5, 1'b1, 50, 1'b1);

      // mid-packet asynchronous reset
      clear_inputs(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h3D; tick();
      clear_inputs(); lfd_state = 1'b1; pkt_valid = 1'b1; tick();
      clear_inputs(); ld_state = 1'b1; data_in = 8'h77; tick();
      check("pre_rst_lpv", low_pkt_valid, 1);
      #2 rst = 1'b0;
      #1 check_all_zero("async_rst");
      clear_inputs(); tick();
      #2 rst = 1'b1;
      m_hdr  = 8'h00;
      m_dout = 8'h00;
      tick();
      check_all_zero("after_rst");

      for (int n = 0; n < 30; n++) begin
         h = byte_t'($urandom);
         send_packet(h, int'($urandom_range(1, 14)), 1'($urandom_range(1)),
                     30, 1'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
